// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and helper functions
//
// Purpose: common definitions for the cascadable BCD decade counter.
//   BCD_W   - width of one decimal digit
//   BCD_MAX - largest legal BCD value (9)
//   is_nine - true when a nibble is exactly 9 (only 9 may carry)
//   bcd_inc - next value of a digit selected to increment; 9 and the
//             illegal codes 10..15 all return to 0
package bcd_pkg;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  function automatic logic is_nine(input logic [BCD_W-1:0] nibble);
    return (nibble == BCD_MAX);
  endfunction

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] nibble);
    // Illegal codes recover to 0 on their first count rather than
    // stepping through 11..15.
    if (nibble >= BCD_MAX) begin
      return '0;
    end
    return nibble + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one registered BCD decade digit with load and increment
//
// Purpose: a single decimal digit of the counter.
// Ports:
//   CLK    in   clock, rising edge
//   CLR_n  in   asynchronous active-low clear
//   load   in   synchronous parallel load (active high), beats inc_en
//   d      in   [3:0] load data
//   inc_en in   increment this digit on the next edge
//   q      out  [3:0] digit state
//   is9    out  digit currently holds exactly 9
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             inc_en,
  output logic [BCD_W-1:0] q,
  output logic             is9
);

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (inc_en) begin
      q <= bcd_inc(q);
    end
  end

  assign is9 = is_nine(q);

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - cascadable multi-digit BCD decade counter (74LS160 style)
//
// Purpose: DIGITS-digit synchronous decimal counter with parallel load,
// dual count enables and a combinational ripple-carry output.
// Ports:
//   CLK    in   clock, rising edge
//   CLR_n  in   asynchronous active-low clear (Q = 0 at once)
//   LOAD_n in   synchronous active-low parallel load, beats counting
//   ENP    in   count enable P (gates counting only)
//   ENT    in   count enable T (gates counting and RCO)
//   D_in   in   [4*DIGITS-1:0] load data, digit k at [4k+3:4k]
//   Q      out  [4*DIGITS-1:0] counter state, same packing
//   RCO    out  ENT & every digit == 9, combinational
// DIGITS is intended for the range 1..4.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 1
) (
  input  logic                      CLK,
  input  logic                      CLR_n,
  input  logic                      LOAD_n,
  input  logic                      ENP,
  input  logic                      ENT,
  input  logic [BCD_W*DIGITS-1:0]   D_in,
  output logic [BCD_W*DIGITS-1:0]   Q,
  output logic                      RCO
);

  logic [DIGITS-1:0] is9;
  // all9_below[k] is high when digits 0..k-1 are all exactly 9; it is
  // the carry into digit k. Index DIGITS covers the whole counter.
  logic [DIGITS:0]   all9_below;
  logic              count_en;

  assign count_en      = ENP & ENT;
  assign all9_below[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign all9_below[k+1] = all9_below[k] & is9[k];

    bcd_digit u_digit (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .load   (~LOAD_n),
      .d      (D_in[BCD_W*k +: BCD_W]),
      .inc_en (count_en & all9_below[k]),
      .q      (Q[BCD_W*k +: BCD_W]),
      .is9    (is9[k])
    );
  end

  // ENP deliberately does not gate RCO so a cascade can pause on ENP
  // while the carry chain still reflects the all-nines state.
  assign RCO = ENT & all9_below[DIGITS];

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - self-checking bench for bcd_counter (1- and 2-digit)
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       clr_n, load_n, enp, ent;
  logic [3:0] d1, q1;
  logic [7:0] d2, q2;
  logic       rco1, rco2;

  logic [15:0] m1, m2;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(1)) u1 (
    .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
    .D_in(d1), .Q(q1), .RCO(rco1)
  );

  bcd_counter #(.DIGITS(2)) u2 (
    .CLK(clk), .CLR_n(clr_n), .LOAD_n(load_n), .ENP(enp), .ENT(ent),
    .D_in(d2), .Q(q2), .RCO(rco2)
  );

  // Reference: the counter's value as a list of decimal digits. A count
  // adds one to digit 0; each digit that was exactly 9 rolls to 0 and
  // passes the increment on, any other digit absorbs it (illegal codes
  // become 0 without passing it on).
  function automatic logic [15:0] ref_next(input logic [15:0] q, input logic [15:0] d,
                                           input logic ld_n, input logic p, input logic t,
                                           input int nd);
    logic [15:0] r;
    int dig;
    if (!ld_n) return d;
    if (!(p && t)) return q;
    r = q;
    for (int k = 0; k < nd; k++) begin
      dig = int'(q[4*k +: 4]);
      r[4*k +: 4] = (dig >= 9) ? 4'd0 : 4'(dig + 1);
      if (dig != 9) break;
    end
    return r;
  endfunction

  function automatic logic ref_rco(input logic [15:0] q, input logic t, input int nd);
    logic all9;
    all9 = 1'b1;
    for (int k = 0; k < nd; k++) begin
      if (int'(q[4*k +: 4]) != 9) all9 = 1'b0;
    end
    return t && all9;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("q1", {12'd0, q1}, {12'd0, m1[3:0]});
    check("rco1", {15'd0, rco1}, {15'd0, ref_rco(m1, ent, 1)});
    check("q2", {8'd0, q2}, {8'd0, m2[7:0]});
    check("rco2", {15'd0, rco2}, {15'd0, ref_rco(m2, ent, 2)});
  endtask

  // One rising edge: advance the model with the inputs that were stable
  // before the edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!clr_n) begin
      m1 = '0;
      m2 = '0;
    end else begin
      m1 = ref_next(m1, {12'd0, d1}, load_n, enp, ent, 1);
      m2 = ref_next(m2, {8'd0, d2}, load_n, enp, ent, 2);
    end
    #1;
    check_model();
  endtask

  task automatic load_both(input logic [7:0] v);
    load_n = 1'b0;
    d2 = v;
    d1 = v[3:0];
    tick();
    load_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;

    clr_n = 1'b1; load_n = 1'b0; enp = 1'b0; ent = 1'b0;
    d1 = 4'd7; d2 = 8'h07;
    m1 = '0; m2 = '0;

    // Asynchronous clear with load pending, before any clock edge.
    #1 clr_n = 1'b0;
    #1;
    check("clr_async_q1", {12'd0, q1}, 16'd0);
    check("clr_async_rco1", {15'd0, rco1}, 16'd0);
    check("clr_async_q2", {8'd0, q2}, 16'd0);
    tick();
    tick();

    // Release, both enables off: hold at 0.
    clr_n = 1'b1; load_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("hold_q1", {12'd0, q1}, 16'd0);

    // Single-digit count and wrap.
    enp = 1'b1; ent = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("count_q1", {12'd0, q1}, 16'((i + 1) % 10));
      check("count_rco1", {15'd0, rco1}, {15'd0, ((i + 1) % 10) == 9});
    end

    // Load beats counting.
    load_both(8'h23);
    load_n = 1'b0; d2 = 8'h47; d1 = 4'h7;
    tick();
    check("load_prio", {8'd0, q2}, 16'h0047);
    load_n = 1'b1;
    tick(); check("after_load_48", {8'd0, q2}, 16'h0048);
    tick(); check("after_load_49", {8'd0, q2}, 16'h0049);
    tick(); check("after_load_50", {8'd0, q2}, 16'h0050);

    // Enable gating around 99.
    load_both(8'h99);
    ent = 1'b0; enp = 1'b1;
    #1 check("ent0_rco", {15'd0, rco2}, 16'd0);
    tick(); check("ent0_hold", {8'd0, q2}, 16'h0099);
    ent = 1'b1; enp = 1'b0;
    #1 check("enp0_rco", {15'd0, rco2}, 16'd1);
    tick(); check("enp0_hold", {8'd0, q2}, 16'h0099);
    enp = 1'b1;
    tick();
    check("wrap_q2", {8'd0, q2}, 16'h0000);
    check("wrap_rco2", {15'd0, rco2}, 16'd0);

    // Illegal digit recovery.
    load_both(8'h0C);
    tick(); check("illegal_0c", {8'd0, q2}, 16'h0000);
    load_both(8'h1F);
    tick(); check("illegal_1f", {8'd0, q2}, 16'h0010);

    // Asynchronous clear between edges while counting.
    load_both(8'h56);
    tick(); check("at_57", {8'd0, q2}, 16'h0057);
    clr_n = 1'b0;
    #1;
    m1 = '0; m2 = '0;
    check("midclr_q2", {8'd0, q2}, 16'h0000);
    check("midclr_q1", {12'd0, q1}, 16'h0000);
    #1 clr_n = 1'b1;
    tick(); check("resume_1", {8'd0, q2}, 16'h0001);
    tick(); check("resume_2", {8'd0, q2}, 16'h0002);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      load_n = (r[2:0] != 3'd0);
      enp = (r[4:3] != 2'd0);
      ent = (r[6:5] != 2'd0);
      d2 = r[15:8];
      d1 = r[19:16];
      if (r[25:20] == 6'd0) begin
        clr_n = 1'b0;
        #1;
        m1 = '0; m2 = '0;
        check_model();
        clr_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
